// File: rtl/cache_fsm_l3_pkg.sv
// Shared configuration for the L3 cache slice.
//   cache_config       : L3 geometry (lines, offset, derived index/tag widths)
//                        and the L3 controller state encoding.
//   main_memory_config : main-memory line width.
// The 2-bit processor ID at the top of the address is not part of the tag,
// so the tag spans address bits [29 : offset+index].
package cache_config;
    localparam int L3_NUM_LINES   = 64;
    localparam int L3_OFFSET_BITS = 4;
    localparam int L3_INDEX_WIDTH = $clog2(L3_NUM_LINES);
    localparam int L3_TAG_WIDTH   = 30 - L3_OFFSET_BITS - L3_INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        EVICT,
        FETCH,
        RESPOND
    } l3_state_t;
endpackage

package main_memory_config;
    localparam int MAIN_MEMORY_DATA_WIDTH = 128;
endpackage

// File: rtl/cache_fsm_l3_line_store.sv
// cache_L3_line_store: tag/valid/dirty/data arrays of the direct-mapped L3.
// Ports:
//   clk, reset            : clock, synchronous active-high reset (clears
//                           valid/dirty only; tags and data keep contents)
//   index                 : line selected for both the read and write port
//   valid/dirty/tag/data  : combinational read of the selected line
//   install               : write tag+data, set valid, dirty <= set_dirty
//   write_data            : overwrite data only (write-back hit)
//   set_dirty/clear_dirty : dirty-bit control when not installing
//   new_tag/new_data      : write values
module cache_L3_line_store #(
    parameter int NUM_LINES = 64,
    parameter int INDEX_W   = $clog2(NUM_LINES),
    parameter int TAG_W     = 20,
    parameter int LINE_W    = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INDEX_W-1:0] index,
    output logic              valid,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag,
    output logic [LINE_W-1:0] data,
    input  logic              install,
    input  logic              write_data,
    input  logic              set_dirty,
    input  logic              clear_dirty,
    input  logic [TAG_W-1:0]  new_tag,
    input  logic [LINE_W-1:0] new_data
);
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (install) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= set_dirty;
        end else if (set_dirty) begin
            dirty_q[index] <= 1'b1;
        end else if (clear_dirty) begin
            dirty_q[index] <= 1'b0;
        end
    end

    // Storage arrays are not reset; a cleared valid bit hides stale contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (install)
                tag_q[index] <= new_tag;
            if (install || write_data)
                data_q[index] <= new_data;
        end
    end
endmodule

// File: rtl/cache_fsm_l3.sv
// cache_fsm_l3: shared direct-mapped write-back L3 controller serving L2 line
// refills and full-line write-backs; misses go to main memory, dirty victims
// are written back first.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   read_from_L3_request              : L2 line read, held until L3_ready
//   write_back_to_L3_request          : L2 write-back, held until verified
//   cache_L3_memory_address           : request address ([31:30] = core ID)
//   write_back_to_L3_data             : write-back line
//   L3_ready / write_data_to_L2_from_L3 : read response pulse and line
//   write_back_to_L3_verified         : write-back response pulse
//   main_memory_*                     : line fetch / victim write interface
//   L3_cache_hit / L3_cache_miss      : lookup result pulses
// Optional macro L3_PERF_COUNTERS_EN adds saturating l3_hit_count,
// l3_miss_count and l3_eviction_count outputs.
module cache_fsm_l3
    import cache_config::*;
    import main_memory_config::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_WIDTH    = MAIN_MEMORY_DATA_WIDTH,
    parameter int NUM_LINES     = L3_NUM_LINES,
    parameter int OFFSET_BITS   = L3_OFFSET_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef L3_PERF_COUNTERS_EN
    output logic [31:0]              l3_hit_count,
    output logic [31:0]              l3_miss_count,
    output logic [31:0]              l3_eviction_count,
`endif
    input  logic                     read_from_L3_request,
    input  logic                     write_back_to_L3_request,
    input  logic [ADDRESS_WIDTH-1:0] cache_L3_memory_address,
    input  logic [LINE_WIDTH-1:0]    write_back_to_L3_data,
    output logic                     L3_ready,
    output logic [LINE_WIDTH-1:0]    write_data_to_L2_from_L3,
    output logic                     write_back_to_L3_verified,
    output logic                     main_memory_read_request,
    output logic                     main_memory_write_request,
    output logic [ADDRESS_WIDTH-1:0] main_memory_address,
    output logic [LINE_WIDTH-1:0]    main_memory_write_data,
    input  logic [LINE_WIDTH-1:0]    main_memory_read_data,
    input  logic                     main_memory_ready,
    output logic                     L3_cache_hit,
    output logic                     L3_cache_miss
);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDRESS_WIDTH - 2 - OFFSET_BITS - INDEX_W;
    localparam int LINE_AW = ADDRESS_WIDTH - 2 - OFFSET_BITS;

    l3_state_t state, next_state;

    // Only the line address (no core ID, no offset) is kept from a request.
    logic [LINE_AW-1:0]    req_line;
    logic                  req_wb;
    logic [LINE_WIDTH-1:0] req_data;
    logic                  unused_addr_bits;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    assign req_index = req_line[INDEX_W-1:0];
    assign req_tag   = req_line[LINE_AW-1:INDEX_W];
    assign unused_addr_bits = ^{cache_L3_memory_address[ADDRESS_WIDTH-1 -: 2],
                                cache_L3_memory_address[OFFSET_BITS-1:0]};

    logic                  ls_valid, ls_dirty;
    logic [TAG_W-1:0]      ls_tag;
    logic [LINE_WIDTH-1:0] ls_data;
    logic                  ls_install, ls_write, ls_set_dirty, ls_clear_dirty;
    logic [LINE_WIDTH-1:0] ls_new_data;

    cache_L3_line_store #(
        .NUM_LINES(NUM_LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_WIDTH)
    ) u_line_store (
        .clk        (clk),
        .reset      (reset),
        .index      (req_index),
        .valid      (ls_valid),
        .dirty      (ls_dirty),
        .tag        (ls_tag),
        .data       (ls_data),
        .install    (ls_install),
        .write_data (ls_write),
        .set_dirty  (ls_set_dirty),
        .clear_dirty(ls_clear_dirty),
        .new_tag    (req_tag),
        .new_data   (ls_new_data)
    );

    logic                     accept, accept_wb, lookup_hit, evict_done;
    logic                     hit_d, miss_d, ready_d, verified_d, mm_rd_d, mm_wr_d;
    logic [LINE_WIDTH-1:0]    rd_line_d, mm_wdata_d;
    logic [ADDRESS_WIDTH-1:0] mm_addr_d, line_addr, victim_addr;

    assign lookup_hit  = ls_valid && (ls_tag == req_tag);
    assign line_addr   = {2'b00, req_line, {OFFSET_BITS{1'b0}}};
    assign victim_addr = {2'b00, ls_tag, req_index, {OFFSET_BITS{1'b0}}};
    assign evict_done  = (state == EVICT) && main_memory_ready;

    always_comb begin
        next_state     = state;
        accept         = 1'b0;
        accept_wb      = 1'b0;
        hit_d          = 1'b0;
        miss_d         = 1'b0;
        ready_d        = 1'b0;
        verified_d     = 1'b0;
        rd_line_d      = write_data_to_L2_from_L3;
        mm_rd_d        = main_memory_read_request;
        mm_wr_d        = main_memory_write_request;
        mm_addr_d      = main_memory_address;
        mm_wdata_d     = main_memory_write_data;
        ls_install     = 1'b0;
        ls_write       = 1'b0;
        ls_set_dirty   = 1'b0;
        ls_clear_dirty = 1'b0;
        ls_new_data    = req_data;
        unique case (state)
            IDLE: begin
                // The response pulse is still visible in the first IDLE
                // cycle; skip it so a held request is not taken twice.
                if (!L3_ready && !write_back_to_L3_verified &&
                    (write_back_to_L3_request || read_from_L3_request)) begin
                    accept     = 1'b1;
                    accept_wb  = write_back_to_L3_request;
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                hit_d  = lookup_hit;
                miss_d = !lookup_hit;
                if (lookup_hit) begin
                    ls_write     = req_wb;
                    ls_set_dirty = req_wb;
                    next_state   = RESPOND;
                end else if (ls_valid && ls_dirty) begin
                    mm_wr_d    = 1'b1;
                    mm_addr_d  = victim_addr;
                    mm_wdata_d = ls_data;
                    next_state = EVICT;
                end else if (!req_wb) begin
                    mm_rd_d    = 1'b1;
                    mm_addr_d  = line_addr;
                    next_state = FETCH;
                end else begin
                    // Full-line write needs no fill from memory.
                    ls_install   = 1'b1;
                    ls_set_dirty = 1'b1;
                    next_state   = RESPOND;
                end
            end
            EVICT: begin
                if (main_memory_ready) begin
                    mm_wr_d = 1'b0;
                    if (req_wb) begin
                        ls_install   = 1'b1;
                        ls_set_dirty = 1'b1;
                        next_state   = RESPOND;
                    end else begin
                        ls_clear_dirty = 1'b1;
                        mm_rd_d        = 1'b1;
                        mm_addr_d      = line_addr;
                        next_state     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (main_memory_ready) begin
                    mm_rd_d     = 1'b0;
                    ls_install  = 1'b1;
                    ls_new_data = main_memory_read_data;
                    next_state  = RESPOND;
                end
            end
            RESPOND: begin
                verified_d = req_wb;
                ready_d    = !req_wb;
                if (!req_wb)
                    rd_line_d = ls_data;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                     <= IDLE;
            req_line                  <= '0;
            req_wb                    <= 1'b0;
            req_data                  <= '0;
            L3_ready                  <= 1'b0;
            write_data_to_L2_from_L3  <= '0;
            write_back_to_L3_verified <= 1'b0;
            main_memory_read_request  <= 1'b0;
            main_memory_write_request <= 1'b0;
            main_memory_address       <= '0;
            main_memory_write_data    <= '0;
            L3_cache_hit              <= 1'b0;
            L3_cache_miss             <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                req_line <= cache_L3_memory_address[ADDRESS_WIDTH-3:OFFSET_BITS];
                req_wb   <= accept_wb;
                req_data <= write_back_to_L3_data;
            end
            L3_ready                  <= ready_d;
            write_data_to_L2_from_L3  <= rd_line_d;
            write_back_to_L3_verified <= verified_d;
            main_memory_read_request  <= mm_rd_d;
            main_memory_write_request <= mm_wr_d;
            main_memory_address       <= mm_addr_d;
            main_memory_write_data    <= mm_wdata_d;
            L3_cache_hit              <= hit_d;
            L3_cache_miss             <= miss_d;
        end
    end

`ifdef L3_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            l3_hit_count      <= '0;
            l3_miss_count     <= '0;
            l3_eviction_count <= '0;
        end else begin
            if (hit_d && l3_hit_count != '1)
                l3_hit_count <= l3_hit_count + 32'd1;
            if (miss_d && l3_miss_count != '1)
                l3_miss_count <= l3_miss_count + 32'd1;
            if (evict_done && l3_eviction_count != '1)
                l3_eviction_count <= l3_eviction_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_fsm_l3.sv
module tb_cache_fsm_l3;
    import cache_config::*;

    localparam int LAT = 3;

    logic         clk, reset;
    logic         read_from_L3_request, write_back_to_L3_request;
    logic [31:0]  cache_L3_memory_address;
    logic [127:0] write_back_to_L3_data;
    logic         L3_ready, write_back_to_L3_verified;
    logic [127:0] write_data_to_L2_from_L3;
    logic         main_memory_read_request, main_memory_write_request;
    logic [31:0]  main_memory_address;
    logic [127:0] main_memory_write_data, main_memory_read_data;
    logic         main_memory_ready;
    logic         L3_cache_hit, L3_cache_miss;
`ifdef L3_PERF_COUNTERS_EN
    logic [31:0]  l3_hit_count, l3_miss_count, l3_eviction_count;
`endif

    cache_fsm_l3 dut (
        .clk                      (clk),
        .reset                    (reset),
`ifdef L3_PERF_COUNTERS_EN
        .l3_hit_count             (l3_hit_count),
        .l3_miss_count            (l3_miss_count),
        .l3_eviction_count        (l3_eviction_count),
`endif
        .read_from_L3_request     (read_from_L3_request),
        .write_back_to_L3_request (write_back_to_L3_request),
        .cache_L3_memory_address  (cache_L3_memory_address),
        .write_back_to_L3_data    (write_back_to_L3_data),
        .L3_ready                 (L3_ready),
        .write_data_to_L2_from_L3 (write_data_to_L2_from_L3),
        .write_back_to_L3_verified(write_back_to_L3_verified),
        .main_memory_read_request (main_memory_read_request),
        .main_memory_write_request(main_memory_write_request),
        .main_memory_address      (main_memory_address),
        .main_memory_write_data   (main_memory_write_data),
        .main_memory_read_data    (main_memory_read_data),
        .main_memory_ready        (main_memory_ready),
        .L3_cache_hit             (L3_cache_hit),
        .L3_cache_miss            (L3_cache_miss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { bit wb; logic [127:0] data; } rsp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [127:0] data; } mem_t;

    rsp_t rsp_q[$];
    mem_t mem_q[$];
    bit   hm_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Memory contents as seen by line address.
    function automatic logic [127:0] mem_line(input logic [31:0] a);
        if (a == 32'h0000_1230) return {16{8'hA5}};
        return {4{a ^ 32'h5A5A_0000}};
    endfunction

    // Reference model of the cache contents.
    bit           rv [64];
    bit           rdy[64];
    logic [19:0]  rt [64];
    logic [127:0] rdt[64];
    int e_hit, e_miss, e_evict;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin rv[i] = 0; rdy[i] = 0; end
        e_hit = 0; e_miss = 0; e_evict = 0;
        rsp_q.delete(); mem_q.delete(); hm_q.delete();
    endtask

    task automatic predict(input bit wb, input logic [31:0] a, input logic [127:0] d);
        logic [5:0]  ix;
        logic [19:0] tg;
        logic [31:0] la;
        rsp_t r;
        mem_t m;
        ix = a[9:4];
        tg = a[29:10];
        la = {2'b00, a[29:4], 4'h0};
        if (rv[ix] && rt[ix] == tg) begin
            e_hit++;
            hm_q.push_back(1'b1);
            if (wb) begin rdt[ix] = d; rdy[ix] = 1; end
        end else begin
            e_miss++;
            hm_q.push_back(1'b0);
            if (rv[ix] && rdy[ix]) begin
                e_evict++;
                m.wr = 1; m.addr = {2'b00, rt[ix], ix, 4'h0}; m.data = rdt[ix];
                mem_q.push_back(m);
            end
            if (wb) begin
                rdt[ix] = d; rdy[ix] = 1;
            end else begin
                m.wr = 0; m.addr = la; m.data = '0;
                mem_q.push_back(m);
                rdt[ix] = mem_line(la); rdy[ix] = 0;
            end
            rv[ix] = 1; rt[ix] = tg;
        end
        r.wb = wb; r.data = rdt[ix];
        rsp_q.push_back(r);
    endtask

    // Main-memory responder: fixed latency, one-cycle ready pulse.
    int poke_n = 0, poke_done = 0;
    initial begin
        int cnt;
        mem_t m;
        cnt = 0;
        main_memory_ready = 0;
        main_memory_read_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0;
                main_memory_ready = 0;
            end else if (main_memory_ready) begin
                main_memory_ready = 0;
            end else if (main_memory_read_request || main_memory_write_request) begin
                chk("mem_excl", main_memory_read_request & main_memory_write_request, 0);
                cnt++;
                if (cnt == LAT) begin
                    cnt = 0;
                    main_memory_ready = 1;
                    main_memory_read_data = mem_line(main_memory_address);
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected", 1, 0);
                    end else begin
                        m = mem_q.pop_front();
                        chk("mem_type", main_memory_write_request, m.wr);
                        chk("mem_addr", main_memory_address, m.addr);
                        if (m.wr) chk("mem_wdata", main_memory_write_data, m.data);
                    end
                end
            end else if (poke_done < poke_n) begin
                main_memory_ready = 1;
                poke_done++;
            end
        end
    end

    // Response and lookup monitor.
    initial begin
        rsp_t r;
        bit   h;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (L3_ready || write_back_to_L3_verified) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_type", {L3_ready, write_back_to_L3_verified}, {!r.wb, r.wb});
                        if (!r.wb) chk("rd_data", write_data_to_L2_from_L3, r.data);
                    end
                end
                if (L3_cache_hit || L3_cache_miss) begin
                    if (hm_q.size() == 0) begin
                        chk("hm_unexpected", 1, 0);
                    end else begin
                        h = hm_q.pop_front();
                        chk("hit_miss", {L3_cache_hit, L3_cache_miss}, {h, !h});
                    end
                end
            end
        end
    end

    task automatic txn(input bit rd, input bit wb, input logic [31:0] a,
                       input logic [127:0] d, output int lat);
        bit rd_done, wb_done;
        if (wb) predict(1, a, d);
        if (rd) predict(0, a, d);
        cache_L3_memory_address  = a;
        write_back_to_L3_data    = d;
        read_from_L3_request     = rd;
        write_back_to_L3_request = wb;
        rd_done = !rd;
        wb_done = !wb;
        lat = -1;
        for (int i = 1; i <= 200 && !(rd_done && wb_done); i++) begin
            @(posedge clk); #1;
            if (write_back_to_L3_verified && write_back_to_L3_request) begin
                write_back_to_L3_request = 0; wb_done = 1;
            end
            if (L3_ready && read_from_L3_request) begin
                read_from_L3_request = 0; rd_done = 1; lat = i - 1;
            end
        end
        if (!(rd_done && wb_done)) begin
            chk("txn_timeout", 0, 1);
            read_from_L3_request = 0;
            write_back_to_L3_request = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero();
        chk("rst_ready",    L3_ready, 0);
        chk("rst_verified", write_back_to_L3_verified, 0);
        chk("rst_mm_rd",    main_memory_read_request, 0);
        chk("rst_mm_wr",    main_memory_write_request, 0);
        chk("rst_mm_addr",  main_memory_address, 0);
        chk("rst_mm_wdata", main_memory_write_data, 0);
        chk("rst_rd_line",  write_data_to_L2_from_L3, 0);
        chk("rst_hitmiss",  {L3_cache_hit, L3_cache_miss}, 0);
        chk("rst_state",    dut.state, IDLE);
`ifdef L3_PERF_COUNTERS_EN
        chk("rst_cnt", {l3_hit_count, l3_miss_count, l3_eviction_count}, 0);
`endif
    endtask

    initial begin
        int lat;
        bit [1:0] pid;
        logic [19:0] tg;
        logic [5:0] ix;
        logic [31:0] a;

        reset = 1;
        read_from_L3_request = 0;
        write_back_to_L3_request = 0;
        cache_L3_memory_address = '0;
        write_back_to_L3_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero();
        reset = 0;
        @(posedge clk); #1;

        // Clean read miss, then the same read hits with no memory traffic.
        txn(1, 0, 32'h0000_1230, '0, lat);
        txn(1, 0, 32'h0000_1230, '0, lat);
        chk("hit_lat", lat, 2);

        // Write-back hit, then read of the same line from another core.
        txn(0, 1, 32'h0000_1230, {16{8'h11}}, lat);
        txn(1, 0, 32'h8000_1230, '0, lat);
        chk("hit_lat_pid", lat, 2);

        // Write-back miss over dirty line: evict, no fetch.
        txn(0, 1, 32'h0000_1630, {16{8'h22}}, lat);
        // Read miss over dirty line: evict then fetch.
        txn(1, 0, 32'h4000_1234, '0, lat);

        // Stray memory ready while idle is ignored.
        poke_n++;
        repeat (3) @(posedge clk);
        #1;
        chk("poke_mm_req", {main_memory_read_request, main_memory_write_request}, 0);
        chk("poke_state", dut.state, IDLE);

        // Read and write-back together: write-back first.
        txn(1, 1, 32'h0000_2240, {16{8'h33}}, lat);

        // Mixed traffic on two indices, several tags and cores.
        for (int k = 0; k < 12; k++) begin
            pid = 2'($urandom_range(0, 3));
            tg  = 20'($urandom_range(4, 6));
            ix  = 6'($urandom_range(35, 36));
            a   = {pid, tg, ix, 4'($urandom_range(0, 15))};
            txn(($urandom_range(0, 1) == 1), 1'b0, a, '0, lat);
            txn(1'b0, 1'b1, {pid, tg, ix, 4'h0}, {$urandom, $urandom, $urandom, $urandom}, lat);
        end

        chk("sb_rsp_drain", rsp_q.size(), 0);
        chk("sb_mem_drain", mem_q.size(), 0);
        chk("sb_hm_drain",  hm_q.size(), 0);
`ifdef L3_PERF_COUNTERS_EN
        chk("cnt_hit",   l3_hit_count, e_hit);
        chk("cnt_miss",  l3_miss_count, e_miss);
        chk("cnt_evict", l3_eviction_count, e_evict);
`endif

        // Reset in the middle of a fetch.
        predict(0, 32'h0000_3000, '0);
        cache_L3_memory_address = 32'h0000_3000;
        read_from_L3_request = 1;
        for (int i = 0; i < 50 && !main_memory_read_request; i++) begin
            @(posedge clk); #1;
        end
        chk("fetch_seen", main_memory_read_request, 1);
        reset = 1;
        read_from_L3_request = 0;
        model_reset();
        @(posedge clk); #1;
        chk_outputs_zero();
        reset = 0;
        @(posedge clk); #1;
        txn(1, 0, 32'h0000_3000, '0, lat);
        txn(1, 0, 32'h0000_3000, '0, lat);
        chk("hit_lat_post_rst", lat, 2);

        chk("sb_rsp_drain2", rsp_q.size(), 0);
        chk("sb_mem_drain2", mem_q.size(), 0);
        chk("sb_hm_drain2",  hm_q.size(), 0);
`ifdef L3_PERF_COUNTERS_EN
        chk("cnt_hit2",   l3_hit_count, e_hit);
        chk("cnt_miss2",  l3_miss_count, e_miss);
        chk("cnt_evict2", l3_eviction_count, e_evict);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cache_fsm_l3.md
Name: cache_fsm_L3

Overview:
- Shared, direct-mapped, write-back last-level cache directly downstream of the four L2 cache FSMs. It serves L2 line reads (refills) and L2 full-line write-backs.
- Misses are serviced from main memory. Dirty victims are evicted to main memory first.
- Processor-ID bits [31:30] are excluded from tag/index, so all cores share L3 lines.

Parameters:
ADDRESS_WIDTH, 32, request address width including 2-bit processor ID
LINE_WIDTH, 128, line width in bits (equals MAIN_MEMORY_DATA_WIDTH)
NUM_LINES, 64, number of L3 lines; power of two
OFFSET_BITS, 4, byte-offset bits within a line

Ports:
clk  input  1  clock
reset  input  1  reset
read_from_L3_request  input  1  L2 line read request; held until L3_ready
write_back_to_L3_request  input  1  L2 line write-back request; held until write_back_to_L3_verified
cache_L3_memory_address  input  ADDRESS_WIDTH  request address
write_back_to_L3_data  input  LINE_WIDTH  write-back line
L3_ready  output  1  read-complete pulse
write_data_to_L2_from_L3  output  LINE_WIDTH  read line; valid while L3_ready=1
write_back_to_L3_verified  output  1  write-back-complete pulse
main_memory_read_request  output  1  line fetch request
main_memory_write_request  output  1  victim write request
main_memory_address  output  ADDRESS_WIDTH  line-aligned memory address, bits [31:30]=0
main_memory_write_data  output  LINE_WIDTH  victim data
main_memory_read_data  input  LINE_WIDTH  fetched line; valid with main_memory_ready
main_memory_ready  input  1  single-cycle completion of current memory request
L3_cache_hit  output  1  one-cycle pulse on hit
L3_cache_miss  output  1  one-cycle pulse on miss

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Address split:
  - index = addr[OFFSET_BITS +: log2(NUM_LINES)]
  - tag = addr[29 : OFFSET_BITS+log2(NUM_LINES)]
  - Offset is ignored.
- Reset: state=IDLE. All valid and dirty bits cleared. All outputs 0. Any in-flight memory request is abandoned without waiting for main_memory_ready. The data array is not cleared.
- All outputs are registered.
- State machine:
  - IDLE: samples requests. If both requests are high, write-back has priority; the read stays pending and is accepted after the write-back response. On accept, latch address, data and type, then go to COMPARE.
  - COMPARE: hit = valid[index] && tags[index]==tag. Pulse L3_cache_hit or L3_cache_miss.
    - Read hit: go to RESPOND.
    - Write-back hit: overwrite line, set dirty, go to RESPOND.
    - Miss with valid && dirty victim: go to EVICT.
    - Other miss, read: go to FETCH.
    - Other miss, write-back: install line (valid=1, dirty=1, new tag), go to RESPOND. No memory fetch for a full-line write.
  - EVICT: drive main_memory_write_request=1, address {2'b00, victim tag, index, 0 offset}, and victim data. Hold until main_memory_ready. Then clear dirty; go to FETCH for a read, or install-and-RESPOND for a write-back.
  - FETCH: drive main_memory_read_request=1 with the request line address. Hold until main_memory_ready. Capture main_memory_read_data, install with valid=1, dirty=0, go to RESPOND.
  - RESPOND: one cycle. Pulse L3_ready with line data for a read, or write_back_to_L3_verified for a write-back. Go to IDLE.
- Handshake:
  - The requester drops its request the cycle after the response pulse.
  - IDLE re-samples only from the cycle after RESPOND, so the same request is never accepted twice.
  - Memory requests are never asserted together and never deassert before main_memory_ready.
- Latency, counted from the IDLE sampling edge:
  - Read hit: response 2 cycles later.
  - Read clean miss: 3 cycles plus memory latency.
  - Dirty miss: adds one memory write.
- main_memory_ready while no memory request is active: ignored.
- write_data_to_L2_from_L3 holds its last value outside L3_ready.

Optional Feature:
- Macro: L3_PERF_COUNTERS_EN.
- Defined: adds output ports l3_hit_count[31:0], l3_miss_count[31:0] and l3_eviction_count[31:0].
  - Counters saturate at 0xFFFF_FFFF.
  - Increment on the hit pulse, the miss pulse, and each EVICT completion respectively.
  - Cleared by reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- cache_config gets: L3_NUM_LINES, L3_OFFSET_BITS, derived L3_INDEX_WIDTH and L3_TAG_WIDTH, and the l3_state_t enum (IDLE, COMPARE, EVICT, FETCH, RESPOND).
- main_memory_config supplies MAIN_MEMORY_DATA_WIDTH.
- One sub-module, cache_L3_line_store:
  - Holds the tag/valid/dirty/data arrays.
  - Combinational read port at index.
  - Single synchronous write port with install/dirty-set/dirty-clear controls.
  - Synchronous clear of valid/dirty on reset.

Test Plan:
- Read 0x0000_1230 after reset with memory returning 0xA5A5...A5 after 3 cycles -> L3_cache_miss, one FETCH at 0x0000_1230, L3_ready with 0xA5..A5. Repeat the read -> L3_cache_hit, L3_ready 2 cycles after sampling, no memory access.
- Write-back 0x0000_1230 data 0x1111...11, then read 0x8000_1230 (processor ID 2) -> hit, returns 0x11..11.
- Write-back 0x0000_1630 (same index 0x23, tag 0x5) over dirty line tag 0x4 -> EVICT writes 0x11..11 to 0x0000_1230, then write_back_to_L3_verified, no FETCH.
- Read and write-back asserted in the same cycle -> write-back serviced and verified first, then L3_ready for the read.
- Reset asserted during FETCH -> next cycle all outputs 0, state IDLE. A subsequent read of the same address misses.
- L3_PERF_COUNTERS_EN defined, run the sequence above -> hit/miss/eviction counts match the scoreboard exactly.
